mem_port_arbiter: RTL and testbench

//   Shares the single byte-wide external RAM port between instruction fetch
//   (IF, 32-bit reads) and the MEM stage (byte/half/word loads and stores).
//   It arbitrates, then sequences each request into little-endian byte

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one byte-wide RAM port between IF word fetches and MEM loads/stores
//
// Grants one requester at a time and splits each request into little-endian
// byte transactions. Read bytes are reassembled into a zero-extended word.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr             IF word-read request (level, held until if_done)
//   if_data/if_done            fetched word (held) and one-cycle completion pulse
//   mem_req/mem_we/mem_len     MEM request, store select, size (0=B, 1=H, 2/3=W)
//   mem_addr/mem_wdata         MEM byte address and store data
//   mem_rdata/mem_done         load data (held) and one-cycle completion pulse
//   stallreq_if/stallreq_mem   stall requests toward the pipeline
//   ram_en/ram_we/ram_addr     RAM strobe, write enable and byte address
//   ram_wdata/ram_rdata        RAM write byte, read byte (one cycle after strobe)
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_LAST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_owner_mem;   // 1 = current transaction belongs to MEM
    logic              r_last_mem;    // 1 = most recent grant went to MEM
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;         // read bytes gathered so far
    logic [1:0]        r_k;           // byte index being issued
    logic [1:0]        r_klast;       // index of the final byte (N-1)
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;
    logic              r_if_done;
    logic              r_mem_done;

    logic              w_grant_mem;
    logic [1:0]        w_mem_klast;
    logic [7:0]        w_wbyte;
    logic [31:0]       w_final;

    // MEM has priority unless it was served last and IF is also waiting.
    assign w_grant_mem = mem_req & ~(if_req & r_last_mem);

    always_comb begin
        case (mem_len)
            2'd0:    w_mem_klast = 2'd0;
            2'd1:    w_mem_klast = 2'd1;
            default: w_mem_klast = 2'd3;
        endcase
    end

    always_comb begin
        case (r_k)
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    // The final read byte arrives during LAST; merge it on its way to the output register.
    always_comb begin
        w_final = r_buf;
        if (!r_we) begin
            case (r_klast)
                2'd0:    w_final[7:0]   = ram_rdata;
                2'd1:    w_final[15:8]  = ram_rdata;
                2'd2:    w_final[23:16] = ram_rdata;
                default: w_final[31:24] = ram_rdata;
            endcase
        end
    end

    assign ram_en       = (r_state == S_XFER);
    assign ram_we       = ram_en & r_we;
    assign ram_addr     = ram_en ? (r_base + ADDR_W'(r_k)) : '0;
    assign ram_wdata    = ram_we ? w_wbyte : 8'h00;

    assign if_data      = r_if_data;
    assign if_done      = r_if_done;
    assign mem_rdata    = r_mem_rdata;
    assign mem_done     = r_mem_done;
    assign stallreq_if  = if_req & ~r_if_done;
    assign stallreq_mem = mem_req & ~r_mem_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_mem <= 1'b0;
            r_last_mem  <= 1'b0;
            r_we        <= 1'b0;
            r_base      <= '0;
            r_wdata     <= 32'h0;
            r_buf       <= 32'h0;
            r_k         <= 2'd0;
            r_klast     <= 2'd0;
            r_if_data   <= 32'h0;
            r_mem_rdata <= 32'h0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req | if_req) begin
                        r_owner_mem <= w_grant_mem;
                        r_last_mem  <= w_grant_mem;
                        r_base      <= w_grant_mem ? mem_addr : if_addr;
                        r_we        <= w_grant_mem & mem_we;
                        r_wdata     <= w_grant_mem ? mem_wdata : 32'h0;
                        r_klast     <= w_grant_mem ? w_mem_klast : 2'd3;
                        r_k         <= 2'd0;
                        r_buf       <= 32'h0;
                        r_state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    // ram_rdata now carries the byte issued in the previous cycle.
                    if (!r_we) begin
                        case (r_k)
                            2'd1:    r_buf[7:0]   <= ram_rdata;
                            2'd2:    r_buf[15:8]  <= ram_rdata;
                            2'd3:    r_buf[23:16] <= ram_rdata;
                            default: ;
                        endcase
                    end
                    if (r_k == r_klast) begin
                        r_state <= S_LAST;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                S_LAST: begin
                    if (r_owner_mem) begin
                        r_mem_rdata <= w_final;
                        r_mem_done  <= 1'b1;
                    end else begin
                        r_if_data   <= w_final;
                        r_if_done   <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                default: begin
                    r_if_done  <= 1'b0;
                    r_mem_done <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic [31:0] if_data, mem_rdata;
    logic        if_done, mem_done, stallreq_if, stallreq_mem;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, none required", name);
    endtask

    // Two memories: ram_mem is what the DUT writes, ref_mem is the bench's expectation.
    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(32'(a + k));
        return v;
    endfunction

    // Byte RAM: read data appears the cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= ram_rd(ram_addr);
        else                   ram_rdata <= 8'($urandom);
        if (ram_en && ram_we)  ram_mem[ram_addr] = ram_wdata;
    end

    typedef struct {
        bit          chk;
        logic [31:0] d;
    } mexp_t;

    logic [31:0] if_q[$];
    mexp_t       mem_q[$];
    logic [39:0] wr_q[$];
    logic [31:0] acc_log[$];
    int          order_log[$];
    int          if_done_cnt = 0;
    int          mem_done_cnt = 0;
    bit          mon_en = 1'b0;
    mexp_t       mon_e;
    logic [39:0] mon_w;

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            check("stallreq_if", {31'b0, stallreq_if}, {31'b0, if_req & ~if_done});
            check("stallreq_mem", {31'b0, stallreq_mem}, {31'b0, mem_req & ~mem_done});
            if (!ram_en) begin
                check("idle_bus", ram_addr | {23'b0, ram_we, ram_wdata}, 32'h0);
            end else begin
                acc_log.push_back(ram_addr);
                if (ram_we) begin
                    if (wr_q.size() == 0) fail_now("unexpected_write");
                    else begin
                        mon_w = wr_q.pop_front();
                        check("wr_addr", ram_addr, mon_w[39:8]);
                        check("wr_byte", {24'b0, ram_wdata}, {24'b0, mon_w[7:0]});
                    end
                end else begin
                    check("rd_wdata", {24'b0, ram_wdata}, 32'h0);
                end
            end
            if (if_done) begin
                if_done_cnt++;
                order_log.push_back(0);
                if (if_q.size() == 0) fail_now("unexpected_if_done");
                else check("if_data", if_data, if_q.pop_front());
            end
            if (mem_done) begin
                mem_done_cnt++;
                order_log.push_back(1);
                if (mem_q.size() == 0) fail_now("unexpected_mem_done");
                else begin
                    mon_e = mem_q.pop_front();
                    if (mon_e.chk) check("mem_rdata", mem_rdata, mon_e.d);
                end
            end
        end
    end

    task automatic wait_done(input bit is_mem, output int lat);
        bit got;
        lat = 0;
        got = 1'b0;
        while (!got) begin
            @(negedge clk);
            if (is_mem ? mem_done : if_done) got = 1'b1;
            else begin
                lat++;
                if (lat > 300) begin
                    fail_now("done_timeout");
                    got = 1'b1;
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE cycle.
    task automatic if_read(input logic [31:0] a, output int lat);
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back(ref_word(a, 4));
        wait_done(1'b0, lat);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic mem_op(input bit we, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd, output int lat);
        int n;
        mexp_t e;
        n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
        if (we) begin
            for (int k = 0; k < n; k++) begin
                wr_q.push_back({32'(a + k), wd[8*k +: 8]});
                ref_mem[32'(a + k)] = wd[8*k +: 8];
            end
            e.chk = 1'b0; e.d = 32'h0;
        end else begin
            e.chk = 1'b1; e.d = ref_word(a, n);
        end
        mem_q.push_back(e);
        wait_done(1'b1, lat);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    initial begin
        int lat, lat_if, l1, l2, c0;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
        mem_len = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        ram_mem[32'h100] = 8'h11; ram_mem[32'h101] = 8'h22; ram_mem[32'h102] = 8'h33; ram_mem[32'h103] = 8'h44;
        ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22; ref_mem[32'h102] = 8'h33; ref_mem[32'h103] = 8'h44;
        ram_mem[32'h0FFF_FFFF] = 8'h3C; ram_mem[32'h1000_0000] = 8'hC3;
        ref_mem[32'h0FFF_FFFF] = 8'h3C; ref_mem[32'h1000_0000] = 8'hC3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_en", {31'b0, ram_en}, 32'h0);
        check("rst_dones", {30'b0, if_done, mem_done}, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // IF word read
        acc_log.delete();
        if_read(32'h100, lat);
        check("t1_latency", lat, 6);
        check("t1_acc_count", acc_log.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_addr", acc_log[i], 32'h100 + i);
        check("t1_if_data_held", if_data, 32'h4433_2211);

        // byte store
        c0 = if_done_cnt;
        mem_op(1'b1, 2'd0, 32'h203, 32'h1234_56A5, lat);
        check("t2_latency", lat, 3);
        check("t2_no_if_done", if_done_cnt, c0);

        // misaligned half load across a 2^28 boundary
        acc_log.delete();
        mem_op(1'b0, 2'd1, 32'h0FFF_FFFF, 32'h0, lat);
        check("t3_latency", lat, 4);
        check("t3_acc_count", acc_log.size(), 2);
        check("t3_addr0", acc_log[0], 32'h0FFF_FFFF);
        check("t3_addr1", acc_log[1], 32'h1000_0000);
        check("t3_mem_rdata", mem_rdata, 32'h0000_C33C);

        // word store and read-back (len 2 and 3)
        mem_op(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, lat);
        check("t5_latency", lat, 6);
        mem_op(1'b0, 2'd2, 32'h10, 32'h0, lat);
        check("t5_rd_latency", lat, 6);
        check("t5_rdata", mem_rdata, 32'hDEAD_BEEF);
        mem_op(1'b0, 2'd3, 32'h11, 32'h0, lat);
        check("t5_len3_rdata", mem_rdata, {8'h00 ^ dflt(32'h14), 24'hDEADBE});

        // simultaneous requests from reset: MEM, then IF, then MEM
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_if_data_rst", if_data, 32'h0);
        check("t4_mem_rdata_rst", mem_rdata, 32'h0);
        order_log.delete();
        fork
            if_read(32'h104, lat_if);
            begin
                mem_op(1'b0, 2'd2, 32'h8000, 32'h0, l1);
                mem_op(1'b0, 2'd0, 32'h8004, 32'h0, l2);
            end
        join
        check("t4_order_count", order_log.size(), 3);
        if (order_log.size() == 3) begin
            check("t4_first_mem", order_log[0], 1);
            check("t4_then_if", order_log[1], 0);
            check("t4_last_mem", order_log[2], 1);
        end
        check("t4_if_wait", lat_if, 13);
        check("t4_mem1_latency", l1, 6);

        // reset during byte 2 of a word read
        c0 = if_done_cnt;
        if_addr = 32'h100;
        if_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_ram_en_after_rst", {31'b0, ram_en}, 32'h0);
        check("t6_if_data_cleared", if_data, 32'h0);
        repeat (8) @(negedge clk);
        check("t6_no_done", if_done_cnt, c0);
        @(posedge clk); #1;
        if_read(32'h100, lat);
        check("t6_reissue_latency", lat, 6);

        // randomized traffic from both ports
        fork
            begin
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    if_read(32'h1000 + 32'($urandom_range(0, 32'hFF0)), lat_if);
                end
            end
            begin
                repeat (50) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    mem_op(1'($urandom), 2'($urandom), 32'h8000 + 32'($urandom_range(0, 255)),
                           $urandom, l1);
                end
            end
        join
        repeat (3) @(negedge clk);
        check("end_if_q_empty", if_q.size(), 0);
        check("end_mem_q_empty", mem_q.size(), 0);
        check("end_wr_q_empty", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
